sprite_line_scheduler: RTL and testbench

Per-scanline sprite scheduler placed between the object register file and the sprite line-buffer drawer. On each line_start it scans the object table in index order and collects up to MAX_HITS active objects whose 16-row band covers the requested line. It then hands those hits one at a time to the drawer over a valid/ready handshake. It replaces the full-frame object-ID buffer with a bounded per-line schedule.

---
 rtl/sprite_line_scheduler_if.sv | 28 ++
 rtl/sprite_line_scheduler.sv | 178 +++++++++++++++++
 tb/tb_sprite_line_scheduler.sv | 313 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/sprite_line_scheduler_if.sv
// Buses of the sprite line scheduler: object table read port and the hit
// handshake toward the line-buffer drawer.
interface sprite_line_scheduler_if;
    logic        obj_rd_en;
    logic [4:0]  obj_rd_addr;
    logic [31:0] obj_rd_data;

    logic        hit_valid;
    logic        hit_ready;
    logic [4:0]  hit_obj_id;
    logic [11:0] hit_x;
    logic [3:0]  hit_row;
    logic [5:0]  hit_sprite;

    modport master (
        output obj_rd_en, obj_rd_addr,
        input  obj_rd_data,
        output hit_valid, hit_obj_id, hit_x, hit_row, hit_sprite,
        input  hit_ready
    );

    modport slave (
        input  obj_rd_en, obj_rd_addr,
        output obj_rd_data,
        input  hit_valid, hit_obj_id, hit_x, hit_row, hit_sprite,
        output hit_ready
    );
endinterface

// File: rtl/sprite_line_scheduler.sv
// Per-scanline sprite scheduler: scans the object table on line_start, keeps
// the first MAX_HITS objects covering the line and streams them to the drawer.
//
// state | meaning
// IDLE  | waiting for line_start
// SCAN  | issuing object table reads 0..NUM_OBJECTS-1
// FLUSH | evaluating the last returned object word
// DRAIN | presenting stored hits over hit_valid/hit_ready
module sprite_line_scheduler #(
    parameter int NUM_OBJECTS = 20,
    parameter int MAX_HITS    = 8,
    parameter int SPRITE_H    = 16,
    parameter int Y_W         = 12
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       line_start,
    input  logic [9:0] line_y,
    input  logic       clear_flags,
    output logic       line_done,
    output logic       busy,
    output logic       hit_overflow,
    output logic       overrun,
    sprite_line_scheduler_if.master bus
);

    localparam int         CNT_W     = $clog2(MAX_HITS + 1);
    localparam int         IDX_W     = $clog2(MAX_HITS);
    localparam logic [4:0] LAST_ADDR = 5'(NUM_OBJECTS - 1);

    typedef enum logic [1:0] {IDLE, SCAN, FLUSH, DRAIN} state_t;

    typedef struct packed {
        logic [4:0]  id;
        logic [11:0] x;
        logic [3:0]  row;
        logic [5:0]  sprite;
    } entry_t;

    state_t             state;
    logic [9:0]         line_y_q;
    logic               rd_en_q;
    logic [4:0]         rd_addr_q;
    logic               eval_valid;
    logic [4:0]         eval_id;
    logic [CNT_W-1:0]   count;
    logic [CNT_W-1:0]   ptr;
    logic               hit_valid_q;
    entry_t             hit_q;
    entry_t             table_q [MAX_HITS];

    logic [Y_W-1:0]     obj_y;
    logic [Y_W-1:0]     line_y_ext;
    logic [Y_W:0]       band_end;
    logic               hit_now;
    logic               store_now;
    logic [CNT_W-1:0]   count_next;
    logic [CNT_W-1:0]   ptr_nxt;
    entry_t             eval_entry;
    entry_t             first_entry;

    assign obj_y      = bus.obj_rd_data[8 +: Y_W];
    assign line_y_ext = {{(Y_W-10){1'b0}}, line_y_q};
    // Band end is computed one bit wider so objects near the top of the
    // y range never wrap around onto low scanlines.
    assign band_end   = {1'b0, obj_y} + (Y_W+1)'(SPRITE_H);

    assign hit_now    = eval_valid & bus.obj_rd_data[1]
                      & (line_y_ext >= obj_y)
                      & ({1'b0, line_y_ext} < band_end);
    assign store_now  = hit_now & (count < CNT_W'(MAX_HITS));
    assign count_next = count + CNT_W'(store_now);
    assign ptr_nxt    = ptr + CNT_W'(1);

    assign eval_entry.id     = eval_id;
    assign eval_entry.x      = bus.obj_rd_data[31:20];
    assign eval_entry.row    = line_y_q[3:0] - obj_y[3:0];
    assign eval_entry.sprite = bus.obj_rd_data[7:2];

    // The first hit of a line may be the very word evaluated in FLUSH.
    assign first_entry = (count == '0) ? eval_entry : table_q[0];

    assign busy            = (state != IDLE);
    assign bus.obj_rd_en   = rd_en_q;
    assign bus.obj_rd_addr = rd_addr_q;
    assign bus.hit_valid   = hit_valid_q;
    assign bus.hit_obj_id  = hit_q.id;
    assign bus.hit_x       = hit_q.x;
    assign bus.hit_row     = hit_q.row;
    assign bus.hit_sprite  = hit_q.sprite;

    always_ff @(posedge clk) begin
        if (!line_start && store_now) begin
            table_q[count[IDX_W-1:0]] <= eval_entry;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state        <= IDLE;
            line_y_q     <= '0;
            rd_en_q      <= 1'b0;
            rd_addr_q    <= '0;
            eval_valid   <= 1'b0;
            eval_id      <= '0;
            count        <= '0;
            ptr          <= '0;
            hit_valid_q  <= 1'b0;
            hit_q        <= '0;
            line_done    <= 1'b0;
            hit_overflow <= 1'b0;
            overrun      <= 1'b0;
        end else begin
            line_done <= 1'b0;
            if (clear_flags) begin
                hit_overflow <= 1'b0;
                overrun      <= 1'b0;
            end
            if (line_start) begin
                // A new line always restarts the scan; an in-flight read of
                // the aborted line is discarded via eval_valid.
                if (state != IDLE) begin
                    overrun <= 1'b1;
                end
                state       <= SCAN;
                line_y_q    <= line_y;
                count       <= '0;
                ptr         <= '0;
                rd_en_q     <= 1'b1;
                rd_addr_q   <= '0;
                eval_valid  <= 1'b0;
                hit_valid_q <= 1'b0;
            end else begin
                eval_valid <= rd_en_q;
                eval_id    <= rd_addr_q;
                count      <= count_next;
                if (hit_now && (count == CNT_W'(MAX_HITS))) begin
                    hit_overflow <= 1'b1;
                end
                case (state)
                    SCAN: begin
                        if (rd_addr_q == LAST_ADDR) begin
                            rd_en_q <= 1'b0;
                            state   <= FLUSH;
                        end else begin
                            rd_addr_q <= rd_addr_q + 5'd1;
                        end
                    end
                    FLUSH: begin
                        ptr <= '0;
                        if (count_next == '0) begin
                            line_done <= 1'b1;
                            state     <= IDLE;
                        end else begin
                            hit_valid_q <= 1'b1;
                            hit_q       <= first_entry;
                            state       <= DRAIN;
                        end
                    end
                    DRAIN: begin
                        if (bus.hit_ready) begin
                            if (ptr_nxt == count) begin
                                hit_valid_q <= 1'b0;
                                line_done   <= 1'b1;
                                state       <= IDLE;
                            end else begin
                                ptr   <= ptr_nxt;
                                hit_q <= table_q[ptr_nxt[IDX_W-1:0]];
                            end
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_sprite_line_scheduler.sv
// Scoreboard bench for sprite_line_scheduler: object table model, reference
// hit list computed from the band rules, decoupled monitor on the hit handshake.
module tb_sprite_line_scheduler;
   localparam int NUM_OBJECTS = 20;
   localparam int MAX_HITS    = 8;
   localparam int SPRITE_H    = 16;

   logic       clk = 1'b0;
   logic       reset_n = 1'b0;
   logic       line_start = 1'b0;
   logic [9:0] line_y = '0;
   logic       clear_flags = 1'b0;
   logic       line_done, busy, hit_overflow, overrun;

   sprite_line_scheduler_if bus();

   sprite_line_scheduler #(
      .NUM_OBJECTS(NUM_OBJECTS), .MAX_HITS(MAX_HITS), .SPRITE_H(SPRITE_H), .Y_W(12)
   ) dut (
      .clk(clk), .reset_n(reset_n), .line_start(line_start), .line_y(line_y),
      .clear_flags(clear_flags), .line_done(line_done), .busy(busy),
      .hit_overflow(hit_overflow), .overrun(overrun), .bus(bus)
   );

   always #10 clk = ~clk;

   int n_pass = 0;
   int n_total = 0;
   int cyc = 0;
   int line_t = 0;
   int first_valid_off = -1;
   int ready_mode = 0;
   int stall_cnt = 0;
   logic manual_ready = 1'b0;
   logic drv_ready = 1'b1;

   logic [31:0] obj_mem [32];
   logic [26:0] exp_q [$];
   int exp_n = 0;
   bit exp_ovf = 0;
   bit exp_overrun = 0;

   logic [26:0] fields;
   assign fields = {bus.hit_obj_id, bus.hit_x, bus.hit_row, bus.hit_sprite};
   assign bus.hit_ready = (ready_mode == 4) ? manual_ready : drv_ready;

   always @(posedge clk) cyc <= cyc + 1;

   always @(posedge clk)
      bus.obj_rd_data <= bus.obj_rd_en ? obj_mem[bus.obj_rd_addr] : 32'($urandom);

   always @(posedge clk) begin
      #1;
      case (ready_mode)
         0: drv_ready = 1'b1;
         1: drv_ready = 1'($urandom_range(0, 1));
         2: drv_ready = 1'b0;
         3: begin
            if (bus.hit_valid && stall_cnt < 5) begin
               drv_ready = 1'b0;
               stall_cnt++;
            end else begin
               drv_ready = 1'b1;
            end
         end
         default: ;
      endcase
   end

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
   endtask

   function automatic logic [31:0] mk(input int x, input int y, input int s, input int a);
      logic [11:0] xx;
      logic [11:0] yy;
      logic [5:0]  ss;
      xx = 12'(x);
      yy = 12'(y);
      ss = 6'(s);
      return {xx, yy, ss, (a != 0), 1'b0};
   endfunction

   // Reference: scan in index order, keep the first MAX_HITS covering objects.
   task automatic model(input int ly);
      int n;
      n = 0;
      for (int i = 0; i < NUM_OBJECTS; i++) begin
         logic [31:0] w;
         int y;
         w = obj_mem[i];
         y = int'(w[19:8]);
         if (w[1] && ly >= y && ly < y + SPRITE_H) begin
            if (n < MAX_HITS) exp_q.push_back({5'(i), w[31:20], 4'(ly - y), w[7:2]});
            else exp_ovf = 1;
            n++;
         end
      end
      exp_n = (n > MAX_HITS) ? MAX_HITS : n;
   endtask

   logic        prev_stall = 1'b0;
   logic        prev_ls = 1'b0;
   logic [26:0] prev_fields = '0;

   always @(negedge clk) begin
      if (reset_n) begin
         if (prev_stall && !prev_ls) begin
            check("stall_valid_held", bus.hit_valid, 1);
            check("stall_fields_held", fields, prev_fields);
         end
         if (bus.hit_valid && first_valid_off < 0) first_valid_off = cyc - line_t;
         if (bus.hit_valid && bus.hit_ready) begin
            check("hit_expected", exp_q.size() > 0, 1);
            if (exp_q.size() > 0) check("hit_fields", fields, exp_q.pop_front());
         end
         prev_stall  = bus.hit_valid && !bus.hit_ready;
         prev_fields = fields;
         prev_ls     = line_start;
      end else begin
         prev_stall = 1'b0;
      end
   end

   task automatic run_line(input int ly, input int rmode);
      int t;
      bit timed;
      timed = (rmode == 0) || (rmode == 3);
      model(ly);
      @(posedge clk); #1;
      line_start = 1'b1;
      line_y = 10'(ly);
      @(posedge clk); #1;
      line_start = 1'b0;
      line_t = cyc - 1;
      first_valid_off = -1;
      stall_cnt = 0;
      ready_mode = rmode;
      @(negedge clk);
      check("start_valid_low", bus.hit_valid, 0);
      check("start_busy", busy, 1);
      check("start_rd_en", bus.obj_rd_en, 1);
      check("start_rd_addr", bus.obj_rd_addr, 0);
      t = 1;
      while (!line_done && t < 400) begin
         @(negedge clk);
         t++;
      end
      check("line_done_seen", line_done, 1);
      if (timed) begin
         check("line_done_cycle", t, 22 + exp_n + ((rmode == 3) ? 5 : 0));
         if (exp_n > 0) check("first_valid_cycle", first_valid_off, 22);
      end
      check("all_hits_emitted", exp_q.size(), 0);
      check("done_valid_low", bus.hit_valid, 0);
      check("done_busy_low", busy, 0);
      check("hit_overflow", hit_overflow, exp_ovf);
      check("overrun", overrun, exp_overrun);
   endtask

   task automatic clear_pulse();
      @(posedge clk); #1;
      clear_flags = 1'b1;
      @(posedge clk); #1;
      clear_flags = 1'b0;
      exp_ovf = 0;
      exp_overrun = 0;
   endtask

   task automatic clear_mem();
      for (int i = 0; i < 32; i++) obj_mem[i] = 32'h0;
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: actual=running required=finished");
      $fatal(1, "watchdog");
   end

   initial begin
      int t;
      bit bad;
      clear_mem();
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("rst_busy", busy, 0);
      check("rst_rd_en", bus.obj_rd_en, 0);
      check("rst_rd_addr", bus.obj_rd_addr, 0);
      check("rst_hit_valid", bus.hit_valid, 0);
      check("rst_line_done", line_done, 0);
      check("rst_flags", {hit_overflow, overrun}, 0);
      reset_n = 1'b1;

      // single hit
      obj_mem[0] = mk(200, 240, 7, 1);
      run_line(245, 0);

      // upper band boundary: 165 is the last row of object 1, 166 is past it
      clear_mem();
      obj_mem[1] = mk(11, 150, 5, 1);
      obj_mem[2] = mk(22, 350, 6, 1);
      run_line(165, 0);
      run_line(166, 0);

      // more candidates than storage
      clear_mem();
      for (int i = 0; i < 10; i++) obj_mem[i] = mk(10 * i + 1, 100, i, 1);
      run_line(110, 0);
      clear_pulse();
      @(negedge clk);
      check("ovf_cleared", hit_overflow, 0);

      // backpressure on a single hit
      clear_mem();
      obj_mem[3] = mk(333, 50, 42, 1);
      run_line(60, 3);

      // abort during DRAIN with two hits pending
      clear_mem();
      obj_mem[0] = mk(10, 300, 1, 1);
      obj_mem[1] = mk(20, 300, 2, 1);
      obj_mem[2] = mk(30, 300, 3, 1);
      manual_ready = 1'b0;
      ready_mode = 4;
      model(305);
      @(posedge clk); #1;
      line_start = 1'b1;
      line_y = 10'd305;
      @(posedge clk); #1;
      line_start = 1'b0;
      t = 0;
      while (!bus.hit_valid && t < 60) begin
         @(negedge clk);
         t++;
      end
      check("abort_valid_seen", bus.hit_valid, 1);
      @(posedge clk); #1;
      manual_ready = 1'b1;
      @(posedge clk); #1;
      manual_ready = 1'b0;
      @(negedge clk);
      check("abort_pending", exp_q.size(), 2);
      exp_q.delete();
      clear_mem();
      obj_mem[5] = mk(77, 20, 9, 1);
      exp_overrun = 1;
      run_line(25, 0);
      clear_pulse();
      @(negedge clk);
      check("overrun_cleared", overrun, 0);

      // no wrap for objects near the top of the y range
      clear_mem();
      obj_mem[0] = mk(5, 4090, 3, 1);
      run_line(2, 0);

      // reset mid-scan, after an overrun has been flagged
      ready_mode = 0;
      @(posedge clk); #1;
      line_start = 1'b1;
      line_y = 10'd2;
      @(posedge clk); #1;
      line_start = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      line_start = 1'b1;
      @(posedge clk); #1;
      line_start = 1'b0;
      @(negedge clk);
      check("overrun_set", overrun, 1);
      repeat (5) @(posedge clk);
      #1;
      reset_n = 1'b0;
      #1;
      check("arst_busy", busy, 0);
      check("arst_rd_en", bus.obj_rd_en, 0);
      check("arst_rd_addr", bus.obj_rd_addr, 0);
      check("arst_hit_valid", bus.hit_valid, 0);
      check("arst_line_done", line_done, 0);
      check("arst_flags", {hit_overflow, overrun}, 0);
      @(negedge clk);
      reset_n = 1'b1;
      exp_q.delete();
      exp_ovf = 0;
      exp_overrun = 0;
      bad = 0;
      repeat (40) begin
         @(negedge clk);
         if (line_done || bus.hit_valid || busy) bad = 1;
      end
      check("no_partial_done", bad, 0);

      // randomized lines around the band edges
      for (int r = 0; r < 14; r++) begin
         int ly;
         ly = $urandom_range(17, 1023);
         for (int i = 0; i < NUM_OBJECTS; i++) begin
            int y;
            if ($urandom_range(0, 4) == 0) y = $urandom_range(0, 4095);
            else y = ly + 1 - $urandom_range(0, 18);
            obj_mem[i] = mk($urandom_range(0, 4095), y, $urandom_range(0, 63),
                            ($urandom_range(0, 3) != 0) ? 1 : 0);
         end
         clear_pulse();
         run_line(ly, (r % 3 == 0) ? 0 : 1);
      end

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end
endmodule
